conv2_seq_ctrl: RTL

Sequencer that runs one conv_layer_2 pass. It pulses start_conv2, then streams image, weights and biases from three synchronous-read ROM/RAMs with data_valid in that order. It then collects every result_valid/map word into a result RAM and reports done/err. It sits between the layer-level top controller and the conv_layer_2 datapath.

---
 rtl/conv2_seq_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/conv2_seq_ctrl.sv
// conv2_seq_ctrl: sequences one conv_layer_2 pass -- streams image, weight and bias
// memories into the datapath, then captures the result stream into a result RAM.
`default_nettype none

module conv2_seq_ctrl #(
   parameter int IN_CHANNELS    = 2,
   parameter int OUT_CHANNELS   = 3,
   parameter int IN_IMG_SIZE    = 12,
   parameter int OUT_IMG_SIZE   = 10,
   parameter int KERNEL_SIZE    = 3,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 8192,
   localparam int NPIX = IN_IMG_SIZE * IN_IMG_SIZE * IN_CHANNELS,
   localparam int NW   = KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS * OUT_CHANNELS,
   localparam int NB   = OUT_CHANNELS,
   localparam int NOUT = OUT_IMG_SIZE * OUT_IMG_SIZE * OUT_CHANNELS,
   localparam int IAW  = (NPIX > 1) ? $clog2(NPIX) : 1,
   localparam int WAW  = (NW > 1)   ? $clog2(NW)   : 1,
   localparam int BAW  = (NB > 1)   ? $clog2(NB)   : 1,
   localparam int RAW  = (NOUT > 1) ? $clog2(NOUT) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  go,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  img_rd,
   output logic [IAW-1:0]        img_addr,
   input  logic [DATA_WIDTH-1:0] img_data,
   output logic                  w_rd,
   output logic [WAW-1:0]        w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   output logic                  b_rd,
   output logic [BAW-1:0]        b_addr,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  start_conv2,
   output logic                  data_valid,
   output logic [DATA_WIDTH-1:0] partial_image_in,
   output logic [DATA_WIDTH-1:0] partial_weights_in,
   output logic [DATA_WIDTH-1:0] partial_biases_in,
   input  logic                  finish_conv2,
   input  logic [DATA_WIDTH-1:0] map,
   input  logic                  result_valid,
   output logic                  res_we,
   output logic [RAW-1:0]        res_addr,
   output logic [DATA_WIDTH-1:0] res_data
);

   localparam int NMAX = (NPIX > NW) ? ((NPIX > NB) ? NPIX : NB) : ((NW > NB) ? NW : NB);
   localparam int CW   = $clog2(NMAX + 1);
   localparam int RCW  = $clog2(NOUT + 1);
   localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_RD_IMG, S_RD_W, S_RD_B, S_DRAIN, S_WAIT_FINISH, S_DONE
   } state_t;

   typedef enum logic [1:0] {SEL_NONE, SEL_IMG, SEL_W, SEL_B} sel_t;

   state_t                state_q, state_d;
   sel_t                  sel_q, sel_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [RCW-1:0]        rcount_q, rcount_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  err_q, err_d;
   logic                  dv_q;
   logic [DATA_WIDTH-1:0] pimg_q, pw_q, pb_q;

   logic cap_act, rcnt_full, wr_ok;

   assign cap_act   = (state_q != S_IDLE) && (state_q != S_DONE);
   assign rcnt_full = (rcount_q == RCW'(NOUT));
   assign wr_ok     = cap_act && result_valid && !rcnt_full;

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign err         = err_q;
   assign start_conv2 = (state_q == S_START);
   assign img_rd      = (state_q == S_RD_IMG);
   assign w_rd        = (state_q == S_RD_W);
   assign b_rd        = (state_q == S_RD_B);
   assign img_addr    = img_rd ? cnt_q[IAW-1:0] : '0;
   assign w_addr      = w_rd   ? cnt_q[WAW-1:0] : '0;
   assign b_addr      = b_rd   ? cnt_q[BAW-1:0] : '0;

   assign data_valid         = dv_q;
   assign partial_image_in   = pimg_q;
   assign partial_weights_in = pw_q;
   assign partial_biases_in  = pb_q;

   assign res_we   = wr_ok;
   assign res_addr = wr_ok ? rcount_q[RAW-1:0] : '0;
   assign res_data = wr_ok ? map : '0;

   always_comb begin
      state_d  = state_q;
      sel_d    = SEL_NONE;
      cnt_d    = cnt_q;
      rcount_d = rcount_q;
      tmo_d    = '0;
      err_d    = err_q;

      // A surplus result is flagged even in DONE, so a straggler right after finish is caught.
      if (busy && result_valid && rcnt_full)
         err_d = 1'b1;
      if (wr_ok)
         rcount_d = rcount_q + RCW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d  = S_START;
               err_d    = 1'b0;
               cnt_d    = '0;
               rcount_d = '0;
            end
         end
         S_START: begin
            if (finish_conv2) err_d = 1'b1;
            cnt_d   = '0;
            state_d = S_RD_IMG;
         end
         S_RD_IMG: begin
            sel_d = SEL_IMG;
            if (finish_conv2) err_d = 1'b1;
            if (cnt_q == CW'(NPIX - 1)) begin
               cnt_d   = '0;
               state_d = S_RD_W;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RD_W: begin
            sel_d = SEL_W;
            if (finish_conv2) err_d = 1'b1;
            if (cnt_q == CW'(NW - 1)) begin
               cnt_d   = '0;
               state_d = S_RD_B;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RD_B: begin
            sel_d = SEL_B;
            if (finish_conv2) err_d = 1'b1;
            if (cnt_q == CW'(NB - 1)) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (finish_conv2) err_d = 1'b1;
            if (cnt_q == CW'(1)) begin
               cnt_d   = '0;
               state_d = S_WAIT_FINISH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_FINISH: begin
            // rcount_d already includes a result arriving together with finish.
            if (finish_conv2) begin
               if (rcount_d != RCW'(NOUT)) err_d = 1'b1;
               state_d = S_DONE;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         sel_q    <= SEL_NONE;
         cnt_q    <= '0;
         rcount_q <= '0;
         tmo_q    <= '0;
         err_q    <= 1'b0;
         dv_q     <= 1'b0;
         pimg_q   <= '0;
         pw_q     <= '0;
         pb_q     <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         rcount_q <= rcount_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
         dv_q     <= (sel_q != SEL_NONE);
         // sel_q marks which memory's read data is on its bus this cycle.
         unique case (sel_q)
            SEL_IMG: pimg_q <= img_data;
            SEL_W:   pw_q   <= w_data;
            SEL_B:   pb_q   <= b_data;
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
